// File: rtl/generic_counter.sv
// Parameterised up-counter with enable and wrap at COUNTER_MAX. TRIG_OUT pulses
// for one cycle as COUNT returns to 0, so stages can be cascaded.
module generic_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  output logic                     TRIG_OUT,
  output logic [COUNTER_WIDTH-1:0] COUNT
);

  // Reject a terminal value that cannot be represented in COUNTER_WIDTH bits.
  if (COUNTER_WIDTH < 1 ||
      64'(COUNTER_MAX) > ((64'd1 << COUNTER_WIDTH) - 64'd1)) begin : g_bad_params
    $error("generic_counter: COUNTER_MAX=%0d does not fit in COUNTER_WIDTH=%0d",
           COUNTER_MAX, COUNTER_WIDTH);
  end

  localparam logic [COUNTER_WIDTH-1:0] MAX_C = COUNTER_WIDTH'(COUNTER_MAX);

  logic [COUNTER_WIDTH-1:0] count_d, count_q;
  logic                     trig_d, trig_q;

  // Next-state: >= rather than == so an out-of-range count still wraps.
  always_comb begin
    count_d = count_q;
    trig_d  = 1'b0;
    if (ENABLE) begin
      if (count_q >= MAX_C) begin
        count_d = COUNTER_WIDTH'(0);
        trig_d  = 1'b1;
      end else begin
        count_d = count_q + COUNTER_WIDTH'(1);
        trig_d  = 1'b0;
      end
    end else begin
      count_d = count_q;
      trig_d  = 1'b0;
    end
  end

  // State register; reset clears both outputs at once and drops any pending pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= COUNTER_WIDTH'(0);
      trig_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      trig_q  <= trig_d;
    end
  end

  assign COUNT    = count_q;
  assign TRIG_OUT = trig_q;

endmodule

// File: tb/tb_generic_counter.sv
// Scoreboard bench: default counter, H(10,62)->V(9,87) cascade and a MAX=0 stage.
module tb_generic_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_d, en_h, en_z;
  logic [3:0] cnt_d;
  logic       trg_d;
  logic [9:0] cnt_h;
  logic       trg_h;
  logic [8:0] cnt_v;
  logic       trg_v;
  logic [3:0] cnt_z;
  logic       trg_z;

  always #5 clk = ~clk;

  generic_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(9)) u_d (
    .CLK(clk), .RESET(rst_n), .ENABLE(en_d), .TRIG_OUT(trg_d), .COUNT(cnt_d));
  generic_counter #(.COUNTER_WIDTH(10), .COUNTER_MAX(62)) u_h (
    .CLK(clk), .RESET(rst_n), .ENABLE(en_h), .TRIG_OUT(trg_h), .COUNT(cnt_h));
  generic_counter #(.COUNTER_WIDTH(9), .COUNTER_MAX(87)) u_v (
    .CLK(clk), .RESET(rst_n), .ENABLE(trg_h), .TRIG_OUT(trg_v), .COUNT(cnt_v));
  generic_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(0)) u_z (
    .CLK(clk), .RESET(rst_n), .ENABLE(en_z), .TRIG_OUT(trg_z), .COUNT(cnt_z));

  typedef struct {
    int d_cnt; bit d_trg;
    int h_cnt; bit h_trg;
    int v_cnt; bit v_trg;
    int z_cnt; bit z_trg;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   k_d = 0;   // enabled edges of u_d since reset
  int   k_h = 0;   // enabled edges of u_h since reset
  bit   done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected state after an edge, written from the counting rules:
  // H period 63, V advances the edge after H wraps, V period 63*88.
  function automatic exp_t expected(input bit td, input bit tz);
    exp_t e;
    e.d_cnt = k_d % 10;
    e.d_trg = td;
    e.h_cnt = k_h % 63;
    e.h_trg = (k_h > 0) && (k_h % 63 == 0);
    e.v_cnt = (k_h == 0) ? 0 : ((k_h - 1) / 63) % 88;
    e.v_trg = (k_h > 1) && ((k_h - 1) % (63 * 88) == 0);
    e.z_cnt = 0;
    e.z_trg = tz;
    return e;
  endfunction

  task automatic push(input bit r, input bit ed, input bit ez);
    bit td;
    bit tz;
    td = 1'b0;
    tz = 1'b0;
    if (!r) begin
      k_d = 0;
      k_h = 0;
    end else begin
      if (ed) begin
        k_d++;
        td = (k_d % 10 == 0);
      end
      k_h++;
      tz = ez;
    end
    sb_q.push_back(expected(td, tz));
  endtask

  task automatic step(input bit r, input bit ed, input bit ez);
    @(negedge clk);
    rst_n = r;
    en_d  = ed;
    en_h  = 1'b1;
    en_z  = ez;
    push(r, ed, ez);
  endtask

  // Monitor: every rising edge presents new outputs; compare against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("d_count", int'(cnt_d), e.d_cnt);
        check("d_trig",  int'(trg_d), int'(e.d_trg));
        check("h_count", int'(cnt_h), e.h_cnt);
        check("h_trig",  int'(trg_h), int'(e.h_trg));
        check("v_count", int'(cnt_v), e.v_cnt);
        check("v_trig",  int'(trg_v), int'(e.v_trg));
        check("z_count", int'(cnt_z), e.z_cnt);
        check("z_trig",  int'(trg_z), int'(e.z_trg));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en_d  = 1'b1;
    en_h  = 1'b1;
    en_z  = 1'b1;
    #1;
    check("reset_count_d", int'(cnt_d), 0);
    check("reset_trig_z",  int'(trg_z), 0);

    // Reset held with ENABLE high, then free-run past a full V wrap.
    // ENABLE of u_d drops for three cycles while COUNT sits at 5.
    repeat (2) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 63 * 88 + 20; i++)
      step(1'b1, !(i >= 5 && i <= 7), 1'b1);

    // Bring u_d to COUNT==MAX, then reset between edges.
    for (int i = 0; i < 10 && (k_d % 10 != 9); i++)
      step(1'b1, 1'b1, 1'b1);
    check("pre_async_count_d", int'(k_d % 10), 9);
    @(negedge clk);
    en_d = 1'b1;
    en_z = 1'b1;
    #2;
    check("pre_async_hw_count_d", int'(cnt_d), 9);
    check("pre_async_trig_z", int'(trg_z), 1);
    rst_n = 1'b0;
    #1;
    check("async_count_d", int'(cnt_d), 0);
    check("async_trig_d",  int'(trg_d), 0);
    check("async_count_h", int'(cnt_h), 0);
    check("async_trig_z",  int'(trg_z), 0);
    push(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
    end
  end

endmodule
